key_box_painter: RTL and testbench



---
 rtl/key_box_painter.sv | 180 ++++++++++++++++++
 tb/tb_key_box_painter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_box_painter.sv
// ---------------------------------------------------------------------------
// key_box_painter
//
// Tracks N_KEYS on-screen key indicators and keeps them in step with the
// requested key state. When a key's request differs from what is on screen,
// a filled BOX_W x BOX_H box is painted into the VGA adapter's plot port,
// one pixel per cycle. A pressed key is painted in DRAW_COLOUR and a released
// key in ERASE_COLOUR. Pending keys are serviced round-robin.
//
// Ports
//   iClock    : sole clock, rising edge
//   iResetn   : asynchronous active-low reset
//   iKeyDown  : requested state per key (1 = highlighted)
//   iHold     : stall; freezes painting while high
//   oX, oY    : pixel coordinate (9-bit x, 8-bit y)
//   oColour   : pixel colour
//   oPlot     : pixel write strobe
//   oBusy     : high while a box is being painted
//   oShown    : on-screen state per key
// ---------------------------------------------------------------------------
module key_box_painter #(
   parameter int         N_KEYS       = 12,
   parameter int         X0           = 66,
   parameter int         PITCH        = 16,
   parameter int         Y0           = 124,
   parameter int         BOX_W        = 4,
   parameter int         BOX_H        = 4,
   parameter logic [2:0] DRAW_COLOUR  = 3'b110,
   parameter logic [2:0] ERASE_COLOUR = 3'b000
) (
   input  logic              iClock,
   input  logic              iResetn,
   input  logic [N_KEYS-1:0] iKeyDown,
   input  logic              iHold,
   output logic [8:0]        oX,
   output logic [7:0]        oY,
   output logic [2:0]        oColour,
   output logic              oPlot,
   output logic              oBusy,
   output logic [N_KEYS-1:0] oShown
);

   localparam int IDX_W = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
   localparam int PX_W  = (BOX_W  > 1) ? $clog2(BOX_W)  : 1;
   localparam int PY_W  = (BOX_H  > 1) ? $clog2(BOX_H)  : 1;

   localparam logic [PX_W-1:0]  PX_LAST  = PX_W'(BOX_W - 1);
   localparam logic [PY_W-1:0]  PY_LAST  = PY_W'(BOX_H - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_KEYS - 1);

   // Reject parameter sets whose boxes would fall off the 320x240 screen.
   if (X0 + (N_KEYS - 1) * PITCH + BOX_W - 1 > 319) begin : g_bad_x
      $error("key_box_painter: rightmost box exceeds x=319");
   end
   if (Y0 + BOX_H - 1 > 239) begin : g_bad_y
      $error("key_box_painter: box exceeds y=239");
   end

   typedef enum logic {
      IDLE,
      PAINT
   } state_t;

   state_t             state;
   logic [N_KEYS-1:0]  shown;
   logic [IDX_W-1:0]   rr;
   logic [IDX_W-1:0]   idx;
   logic               mode;
   logic [PX_W-1:0]    px;
   logic [PY_W-1:0]    py;

   // -------------------------------------------------------------------------
   // Round-robin pick: rotate the mismatch vector so bit 0 is key rr, find the
   // lowest set bit, then add rr back modulo N_KEYS.
   // -------------------------------------------------------------------------
   logic [N_KEYS-1:0]   mismatch;
   logic [2*N_KEYS-1:0] mismatch_dbl;
   logic [N_KEYS-1:0]   mismatch_rot;
   logic [IDX_W-1:0]    offset;
   logic                offset_found;
   logic [IDX_W:0]      pick_sum;
   logic [IDX_W-1:0]    next_idx;

   assign mismatch     = iKeyDown ^ shown;
   assign mismatch_dbl = {mismatch, mismatch} >> rr;
   assign mismatch_rot = mismatch_dbl[N_KEYS-1:0];

   always_comb begin
      // NOTE: every variable driven here gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      offset       = '0;
      offset_found = 1'b0;
      for (int i = 0; i < N_KEYS; i++) begin
         if (!offset_found && mismatch_rot[i]) begin
            offset       = IDX_W'(i);
            offset_found = 1'b1;
         end
      end
      pick_sum = {1'b0, rr} + {1'b0, offset};
      if (pick_sum >= (IDX_W + 1)'(N_KEYS)) begin
         pick_sum = pick_sum - (IDX_W + 1)'(N_KEYS);
      end
      next_idx = pick_sum[IDX_W-1:0];
   end

   // Coordinates are formed at 10 bits and truncated to the port widths.
   logic [9:0] x_sum;
   logic [9:0] y_sum;

   assign x_sum = 10'(X0) + 10'(PITCH) * 10'(idx) + 10'(px);
   assign y_sum = 10'(Y0) + 10'(py);

   // -------------------------------------------------------------------------
   // Controller: all state and outputs registered in one process.
   // -------------------------------------------------------------------------
   always_ff @(posedge iClock or negedge iResetn) begin
      if (!iResetn) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         state   <= IDLE;
         shown   <= '0;
         rr      <= '0;
         idx     <= '0;
         mode    <= 1'b0;
         px      <= '0;
         py      <= '0;
         oX      <= '0;
         oY      <= '0;
         oColour <= '0;
         oPlot   <= 1'b0;
         oBusy   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               oPlot <= 1'b0;
               if (|mismatch) begin
                  idx   <= next_idx;
                  mode  <= iKeyDown[next_idx];
                  px    <= '0;
                  py    <= '0;
                  oBusy <= 1'b1;
                  state <= PAINT;
               end
            end

            PAINT: begin
               if (iHold) begin
                  // Stall: drop the strobe, keep coordinates and counters.
                  oPlot <= 1'b0;
               end else begin
                  oX      <= x_sum[8:0];
                  oY      <= y_sum[7:0];
                  oColour <= mode ? DRAW_COLOUR : ERASE_COLOUR;
                  oPlot   <= 1'b1;
                  if (px == PX_LAST) begin
                     px <= '0;
                     if (py == PY_LAST) begin
                        // Last pixel of the box: commit and move the pointer.
                        py         <= '0;
                        shown[idx] <= mode;
                        rr         <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                        oBusy      <= 1'b0;
                        state      <= IDLE;
                     end else begin
                        py <= py + 1'b1;
                     end
                  end else begin
                     px <= px + 1'b1;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign oShown = shown;

endmodule

// File: tb/tb_key_box_painter.sv
// ---------------------------------------------------------------------------
// tb_key_box_painter
//
// Self-checking bench for key_box_painter with default parameters. A
// behavioural model describes each box as a numbered pixel sequence
// (pixel n sits at column n % BOX_W, row n / BOX_W) and a compare process
// checks every DUT output against it on each falling clock edge. Directed
// scenarios pin the model with hand-computed coordinates, then a random
// phase toggles keys and hold.
// ---------------------------------------------------------------------------
module tb_key_box_painter;

   localparam int         N      = 12;
   localparam int         X0     = 66;
   localparam int         PITCH  = 16;
   localparam int         Y0     = 124;
   localparam int         BW     = 4;
   localparam int         BH     = 4;
   localparam logic [2:0] DRAW   = 3'b110;
   localparam logic [2:0] ERASE  = 3'b000;

   logic          iClock = 1'b0;
   logic          iResetn;
   logic [N-1:0]  iKeyDown;
   logic          iHold;
   logic [8:0]    oX;
   logic [7:0]    oY;
   logic [2:0]    oColour;
   logic          oPlot;
   logic          oBusy;
   logic [N-1:0]  oShown;

   key_box_painter #(
      .N_KEYS(N), .X0(X0), .PITCH(PITCH), .Y0(Y0), .BOX_W(BW), .BOX_H(BH),
      .DRAW_COLOUR(DRAW), .ERASE_COLOUR(ERASE)
   ) dut (
      .iClock  (iClock),
      .iResetn (iResetn),
      .iKeyDown(iKeyDown),
      .iHold   (iHold),
      .oX      (oX),
      .oY      (oY),
      .oColour (oColour),
      .oPlot   (oPlot),
      .oBusy   (oBusy),
      .oShown  (oShown)
   );

   always #5 iClock = ~iClock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // -------------------------------------------------------------------------
   // Behavioural model
   // -------------------------------------------------------------------------
   logic [8:0]   m_x;
   logic [7:0]   m_y;
   logic [2:0]   m_c;
   logic         m_plot;
   logic         m_busy;
   logic [N-1:0] m_shown;
   int           m_rr;
   int           m_idx;
   int           m_n;
   logic         m_mode;

   function automatic int pick(input logic [N-1:0] mism, input int from);
      for (int i = 0; i < N; i++) begin
         if (mism[(from + i) % N]) return (from + i) % N;
      end
      return 0;
   endfunction

   always @(posedge iClock or negedge iResetn) begin
      if (!iResetn) begin
         m_x <= '0; m_y <= '0; m_c <= '0; m_plot <= 1'b0; m_busy <= 1'b0;
         m_shown <= '0; m_rr <= 0; m_idx <= 0; m_n <= 0; m_mode <= 1'b0;
      end else if (!m_busy) begin
         m_plot <= 1'b0;
         if ((iKeyDown ^ m_shown) != '0) begin
            m_idx  <= pick(iKeyDown ^ m_shown, m_rr);
            m_mode <= iKeyDown[pick(iKeyDown ^ m_shown, m_rr)];
            m_n    <= 0;
            m_busy <= 1'b1;
         end
      end else if (iHold) begin
         m_plot <= 1'b0;
      end else begin
         m_x    <= 9'(X0 + m_idx * PITCH + m_n % BW);
         m_y    <= 8'(Y0 + m_n / BW);
         m_c    <= m_mode ? DRAW : ERASE;
         m_plot <= 1'b1;
         if (m_n == BW * BH - 1) begin
            m_shown[m_idx] <= m_mode;
            m_rr           <= (m_idx + 1) % N;
            m_busy         <= 1'b0;
         end else begin
            m_n <= m_n + 1;
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   logic compare_on = 1'b0;

   always @(negedge iClock) begin
      if (compare_on) begin
         check("cycle", 64'({oX, oY, oColour, oPlot, oBusy, oShown}),
                        64'({m_x, m_y, m_c, m_plot, m_busy, m_shown}));
      end
   end

   // Plotted-pixel log used by the directed checks.
   typedef struct {
      int x;
      int y;
      int c;
      int cyc;
   } pixel_t;

   pixel_t pix[$];
   int     cyc = 0;

   always @(negedge iClock) begin
      cyc <= cyc + 1;
      if (iResetn && oPlot) pix.push_back('{int'(oX), int'(oY), int'(oColour), cyc});
   end

   // -------------------------------------------------------------------------
   // Helpers: inputs change 1 time unit after the falling edge.
   // -------------------------------------------------------------------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge iClock);
         #1;
      end
   endtask

   task automatic settle(input int budget);
      int b = 0;
      while ((oBusy || oShown !== iKeyDown) && b < budget) begin
         tick();
         b++;
      end
      if (b >= budget) check("settle_timeout", 1, 0);
   endtask

   // Counts pixels whose coordinates/colour break the raster for key k.
   function automatic int raster_errors(input int first, input int k, input int colour);
      int bad = 0;
      for (int i = 0; i < BW * BH; i++) begin
         if (pix[first + i].x != X0 + k * PITCH + i % BW ||
             pix[first + i].y != Y0 + i / BW ||
             pix[first + i].c != colour) bad++;
      end
      return bad;
   endfunction

   // -------------------------------------------------------------------------
   // Stimulus
   // -------------------------------------------------------------------------
   initial begin
      int cnt;
      int busy;
      int guard;

      iResetn  = 1'b0;
      iKeyDown = '0;
      iHold    = 1'b0;
      tick(2);
      check("reset_outputs", 64'({oX, oY, oColour, oPlot, oBusy, oShown}), 64'(0));
      compare_on = 1'b1;
      iResetn    = 1'b1;
      tick();

      // Asynchronous reset in the middle of a box.
      iKeyDown = 12'h001;
      tick(5);
      check("painting_before_reset", 64'(oPlot), 64'(1));
      #2;
      iResetn = 1'b0;
      #1;
      check("async_reset", 64'({oX, oY, oColour, oPlot, oBusy, oShown}), 64'(0));
      iKeyDown = '0;
      tick();
      iResetn = 1'b1;
      tick();

      // Press key 0.
      pix.delete();
      iKeyDown = 12'h001;
      settle(100);
      check("press0_count", 64'(pix.size()), 64'(16));
      check("press0_first", 64'({pix[0].x, pix[0].y, pix[0].c}), 64'({32'd66, 32'd124, 32'd6}) );
      check("press0_last", 64'({pix[15].x, pix[15].y}), 64'({32'd69, 32'd127}));
      check("press0_raster", 64'(raster_errors(0, 0, 6)), 64'(0));
      check("press0_shown", 64'(oShown), 64'(12'h001));

      // Release key 0.
      pix.delete();
      iKeyDown = 12'h000;
      settle(100);
      check("release0_count", 64'(pix.size()), 64'(16));
      check("release0_raster", 64'(raster_errors(0, 0, 0)), 64'(0));
      check("release0_shown", 64'(oShown), 64'(0));

      // Round-robin from rr=0: key 3 before key 11, one idle gap between.
      iResetn = 1'b0;
      tick();
      iResetn = 1'b1;
      tick();
      pix.delete();
      iKeyDown = 12'h808;
      settle(200);
      check("rr_count", 64'(pix.size()), 64'(32));
      check("rr_first_key3", 64'(pix[0].x), 64'(114));
      check("rr_key3_raster", 64'(raster_errors(0, 3, 6)), 64'(0));
      check("rr_second_key11", 64'(pix[16].x), 64'(242));
      check("rr_key11_raster", 64'(raster_errors(16, 11, 6)), 64'(0));
      check("rr_gap", 64'(pix[16].cyc - pix[15].cyc), 64'(2));
      check("rr_shown", 64'(oShown), 64'(12'h808));

      // Paint key 5 so the pointer moves to 6; then 3 and 11 together pick 11.
      iKeyDown = 12'h828;
      settle(100);
      pix.delete();
      iKeyDown = 12'h020;
      settle(200);
      check("rr2_first_key11", 64'({pix[0].x, pix[0].c}), 64'({32'd242, 32'd0}));
      check("rr2_second_key3", 64'({pix[16].x, pix[16].c}), 64'({32'd114, 32'd0}));
      check("rr2_shown", 64'(oShown), 64'(12'h020));
      iKeyDown = '0;
      settle(100);

      // Hold for 5 cycles after the 6th pixel.
      pix.delete();
      iKeyDown = 12'h001;
      cnt   = 0;
      busy  = 0;
      guard = 0;
      while (cnt < 6 && guard < 100) begin
         tick();
         guard++;
         if (oBusy) busy++;
         if (oPlot) cnt++;
      end
      if (guard >= 100) check("hold_wait_timeout", 1, 0);
      iHold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) begin
            @(negedge iClock);
            iHold = 1'b0;
            #1;
         end else begin
            tick();
         end
         if (oBusy) busy++;
         check("hold_plot_low", 64'(oPlot), 64'(0));
         check("hold_frozen", 64'({oX, oY}), 64'({9'd67, 8'd125}));
      end
      tick();
      if (oBusy) busy++;
      check("hold_resume", 64'({oPlot, oX, oY}), 64'({1'b1, 9'd68, 8'd125}));
      guard = 0;
      while (oBusy && guard < 100) begin
         tick();
         guard++;
         if (oBusy) busy++;
      end
      if (guard >= 100) check("hold_finish_timeout", 1, 0);
      check("hold_busy_cycles", 64'(busy), 64'(21));
      check("hold_pixels", 64'(raster_errors(0, 0, 6)), 64'(0));
      iKeyDown = '0;
      settle(100);

      // Press key 5 and release it during pixel 8: draw completes, then erase.
      pix.delete();
      iKeyDown = 12'h020;
      cnt   = 0;
      guard = 0;
      while (cnt < 8 && guard < 100) begin
         tick();
         guard++;
         if (oPlot) cnt++;
      end
      if (guard >= 100) check("toggle_wait_timeout", 1, 0);
      iKeyDown = '0;
      settle(200);
      check("toggle_count", 64'(pix.size()), 64'(32));
      check("toggle_draw", 64'(raster_errors(0, 5, 6)), 64'(0));
      check("toggle_erase", 64'(raster_errors(16, 5, 0)), 64'(0));
      check("toggle_shown5", 64'(oShown[5]), 64'(0));

      // Random phase: key toggles and stalls checked by the compare process.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) iKeyDown[$urandom_range(0, N - 1)] ^= 1'b1;
         iHold = ($urandom_range(0, 7) == 0);
         tick();
      end
      iHold = 1'b0;
      settle(N * (BW * BH + 1) + 50);
      check("random_final_shown", 64'(oShown), 64'(iKeyDown));

      tick(2);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
